// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD digit width, limits and digit helpers for the up/down counter.
package bcd_updown_counter_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  function automatic logic is_bcd(input logic [BCD_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

  // Illegal codes 10..15 are replaced by zero so the count stays a legal decade.
  function automatic logic [BCD_W-1:0] bcd_sanitize(input logic [BCD_W-1:0] d);
    return is_bcd(d) ? d : BCD_MIN;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade register with load, step and a carry/borrow-out.
module bcd_digit
  import bcd_updown_counter_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_d,
  input  logic             step,
  input  logic             up,
  output logic [BCD_W-1:0] q,
  output logic             co
);

  logic [BCD_W-1:0] q_next;

  // Load wins over step; stepping wraps 9->0 going up and 0->9 going down.
  always_comb begin
    q_next = q;
    if (ld) begin
      q_next = bcd_sanitize(ld_d);
    end else if (step) begin
      if (up) begin
        q_next = (q == BCD_MAX) ? BCD_MIN : q + BCD_W'(1);
      end else begin
        q_next = (q == BCD_MIN) ? BCD_MAX : q - BCD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= BCD_MIN;
    end else begin
      q <= q_next;
    end
  end

  assign co = step & (up ? (q == BCD_MAX) : (q == BCD_MIN));

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-decade BCD up/down counter with parallel load, terminal count and wrap pulse.
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 2
)
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    tc,
  output logic                    wrap,
  output logic                    load_err
);

  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] co;
  logic              any_bad;

  // Ripple the enable through the decades: a digit steps only when all lower ones roll over.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign step[i] = en;
    end else begin : g_upper
      assign step[i] = co[i-1];
    end

    bcd_digit u_digit (
      .clk    (clk),
      .resetn (resetn),
      .ld     (load),
      .ld_d   (load_val[BCD_W*i +: BCD_W]),
      .step   (step[i]),
      .up     (up),
      .q      (count[BCD_W*i +: BCD_W]),
      .co     (co[i])
    );
  end

  always_comb begin
    any_bad = 1'b0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (!is_bcd(load_val[BCD_W*d +: BCD_W])) begin
        any_bad = 1'b1;
      end
    end
  end

  // Carry out of the top decade means this enabled step wraps; load masks it.
  assign tc = co[DIGITS-1] & ~load;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      wrap     <= 1'b0;
      load_err <= any_bad;
    end else begin
      wrap     <= tc;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed and model-checked stimulus for the 2-decade BCD up/down counter.
module tb_bcd_updown_counter;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         tc;
  logic         wrap;
  logic         load_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic l, input logic [W-1:0] lv, input logic e, input logic u);
    load = l; load_val = lv; en = e; up = u;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int           m;
  logic         m_err;
  logic         m_wrap;
  logic         m_tc;
  logic [3:0]   lo;
  logic [3:0]   hi;
  logic [W-1:0] exp_cnt;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'h00);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_err", 32'(load_err), 32'h0);
    resetn = 1'b1;

    // bad-digit load then count up to 47
    drive(1'b1, 8'h4C, 1'b0, 1'b1); tick();
    check("ld4C_count", 32'(count), 32'h40);
    check("ld4C_err", 32'(load_err), 32'h1);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    repeat (7) tick();
    check("up_to_47", 32'(count), 32'h47);
    check("err_sticky", 32'(load_err), 32'h1);

    // asynchronous reset mid-count, between clock edges
    #2 resetn = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'h00);
    check("async_rst_wrap", 32'(wrap), 32'h0);
    check("async_rst_err", 32'(load_err), 32'h0);
    #1 resetn = 1'b1;

    // 98 -> 99 (tc) -> 00 with wrap pulse -> 01
    drive(1'b1, 8'h98, 1'b0, 1'b1); tick();
    check("ld98", 32'(count), 32'h98);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    check("tc_at98", 32'(tc), 32'h0);
    tick();
    check("cnt99", 32'(count), 32'h99);
    check("tc_at99", 32'(tc), 32'h1);
    check("wrap_at99", 32'(wrap), 32'h0);
    tick();
    check("cnt00_wrap", 32'(count), 32'h00);
    check("wrap_pulse", 32'(wrap), 32'h1);
    check("tc_at00_up", 32'(tc), 32'h0);
    tick();
    check("cnt01", 32'(count), 32'h01);
    check("wrap_one_cycle", 32'(wrap), 32'h0);

    // borrow 10 -> 09, then 00 -> 99 with wrap
    drive(1'b1, 8'h10, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
    check("borrow_09", 32'(count), 32'h09);
    check("borrow_nowrap", 32'(wrap), 32'h0);
    drive(1'b1, 8'h00, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    check("tc_at00_dn", 32'(tc), 32'h1);
    tick();
    check("dn_wrap_99", 32'(count), 32'h99);
    check("dn_wrap_pulse", 32'(wrap), 32'h1);

    // load sanitising and load_err update
    drive(1'b1, 8'h3C, 1'b0, 1'b1); tick();
    check("ld3C_count", 32'(count), 32'h30);
    check("ld3C_err", 32'(load_err), 32'h1);
    drive(1'b1, 8'h25, 1'b0, 1'b1); tick();
    check("ld25_count", 32'(count), 32'h25);
    check("ld25_err", 32'(load_err), 32'h0);
    drive(1'b1, 8'hF9, 1'b0, 1'b1); tick();
    check("ldF9_count", 32'(count), 32'h09);
    check("ldF9_err", 32'(load_err), 32'h1);

    // load beats en at terminal count; tc masked
    drive(1'b1, 8'h99, 1'b0, 1'b1); tick();
    drive(1'b1, 8'h50, 1'b1, 1'b1);
    check("tc_masked_by_load", 32'(tc), 32'h0);
    tick();
    check("ld_over_en", 32'(count), 32'h50);
    check("ld_over_en_wrap", 32'(wrap), 32'h0);

    // direction change with no dead cycle, then hold
    drive(1'b0, 8'h00, 1'b1, 1'b1); tick();
    check("dir_up_51", 32'(count), 32'h51);
    drive(1'b0, 8'h00, 1'b1, 1'b0); tick();
    check("dir_dn_50", 32'(count), 32'h50);
    tick();
    check("dir_dn_49", 32'(count), 32'h49);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("tc_hold", 32'(tc), 32'h0);
    repeat (3) tick();
    check("hold_49", 32'(count), 32'h49);

    // pseudo-random sequence against a decimal model
    m = 49; m_err = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(0, 7) == 0), W'($urandom), 1'($urandom), 1'($urandom));
      m_tc = 1'b0;
      if (load) begin
        lo = (load_val[3:0] > 4'd9) ? 4'd0 : load_val[3:0];
        hi = (load_val[7:4] > 4'd9) ? 4'd0 : load_val[7:4];
        m_err  = (load_val[3:0] > 4'd9) || (load_val[7:4] > 4'd9);
        m      = int'(hi) * 10 + int'(lo);
        m_wrap = 1'b0;
      end else if (en) begin
        m_tc   = up ? (m == 99) : (m == 0);
        m      = up ? (m + 1) % 100 : (m + 99) % 100;
        m_wrap = m_tc;
      end else begin
        m_wrap = 1'b0;
      end
      check("rnd_tc", 32'(tc), 32'(m_tc));
      tick();
      exp_cnt = {4'(m / 10), 4'(m % 10)};
      check("rnd_count", 32'(count), 32'(exp_cnt));
      check("rnd_wrap", 32'(wrap), 32'(m_wrap));
      check("rnd_err", 32'(load_err), 32'(m_err));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
